// File: rtl/wb_check_pkg.sv
// Shared types for the writeback commit checker.
// State encoding plus the default-width golden entry.
package wb_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and simultaneous push/pop.
// Overflowing pushes and underflowing pops are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == CNT_FULL);
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i)
      mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/wb_commit_checker.sv
// Commit-stream checker: compares writebacks to a golden FIFO,
// detects end of program, runs a watchdog, latches first error.
import wb_check_pkg::*;

module wb_commit_checker #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 5,
  parameter int MAX_CYCLES   = 1024,
  parameter int FAIL_FAST    = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              fetch_valid_i,
  input  logic [31:0]       fetch_instr_i,
  input  logic              commit_valid_i,
  input  logic [REG_AW-1:0] commit_rd_i,
  input  logic [DATA_W-1:0] commit_data_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [REG_AW-1:0] exp_rd_i,
  input  logic [DATA_W-1:0] exp_data_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  commit_count_o,
  output logic [REG_AW-1:0] first_err_rd_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic [DATA_W-1:0] first_err_exp_o
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int DW  = (DRAIN_CYCLES > 1) ?
                       $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT =
    CNT_W'(MAX_CYCLES - 1);
  localparam logic [DW-1:0]    DR_LOAD  =
    DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]    DR_ONE   = 1;
  localparam logic [FAW:0]     FQ_ONE   = 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  state_e            state;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  commit_cnt;
  logic              err_seen;
  logic              timeout_q;
  logic [REG_AW-1:0] ferr_rd;
  logic [DATA_W-1:0] ferr_got;
  logic [DATA_W-1:0] ferr_exp;

  exp_t              push_ent;
  exp_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FAW:0]      fifo_cnt;

  logic active;
  logic cmp_fire;
  logic push;
  logic pop;
  logic err_hit;
  logic match;
  logic wd_hit;
  logic drain_done;
  logic empty_next;
  logic err_free;
  logic fetch_end;

  assign active     = (state == ST_RUN) ||
                      (state == ST_DRAIN);
  assign cmp_fire   = active && commit_valid_i &&
                      (commit_rd_i != '0) && !start_i;
  assign push       = exp_valid_i && !fifo_full;
  assign pop        = cmp_fire && !fifo_empty;
  assign err_hit    = cmp_fire &&
                      (fifo_empty ||
                       head.rd != commit_rd_i ||
                       head.data != commit_data_i);
  assign match      = cmp_fire && !err_hit;
  assign wd_hit     = active && (cycle_cnt == WD_LIMIT);
  assign drain_done = (state == ST_DRAIN) &&
                      (drain_cnt == '0);
  assign fetch_end  = fetch_valid_i &&
                      (fetch_instr_i == '0);
  // FIFO occupancy as it will be after this cycle's push/pop
  assign empty_next = !push &&
                      (fifo_empty ||
                       (pop && fifo_cnt == FQ_ONE));
  assign err_free   = (err_cnt == '0) && !err_hit;
  assign push_ent   = '{rd: exp_rd_i, data: exp_data_i};

  sync_fifo #(
    .WIDTH (REG_AW + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .flush_i (start_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_ent),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      cycle_cnt  <= '0;
      err_cnt    <= '0;
      commit_cnt <= '0;
      err_seen   <= 1'b0;
      timeout_q  <= 1'b0;
      ferr_rd    <= '0;
      ferr_got   <= '0;
      ferr_exp   <= '0;
    end else if (start_i) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      cycle_cnt  <= '0;
      err_cnt    <= '0;
      commit_cnt <= '0;
      err_seen   <= 1'b0;
      timeout_q  <= 1'b0;
      ferr_rd    <= '0;
      ferr_got   <= '0;
      ferr_exp   <= '0;
    end else begin
      if (active && cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if (match && commit_cnt != CNT_MAX)
        commit_cnt <= commit_cnt + CNT_ONE;
      if (err_hit) begin
        if (err_cnt != CNT_MAX)
          err_cnt <= err_cnt + CNT_ONE;
        if (!err_seen) begin
          err_seen <= 1'b1;
          ferr_rd  <= commit_rd_i;
          ferr_got <= commit_data_i;
          ferr_exp <= fifo_empty ? '0 : head.data;
        end
      end
      unique case (state)
        ST_RUN, ST_DRAIN: begin
          if (wd_hit) begin
            state     <= ST_FAIL;
            timeout_q <= 1'b1;
          end else if (err_hit && FAIL_FAST != 0) begin
            state <= ST_FAIL;
          end else if (drain_done) begin
            state <= (err_free && empty_next) ?
                     ST_PASS : ST_FAIL;
          end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt - DR_ONE;
          end else if (fetch_end) begin
            state     <= ST_DRAIN;
            drain_cnt <= DR_LOAD;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign exp_ready_o     = !fifo_full;
  assign done_o          = (state == ST_PASS) ||
                           (state == ST_FAIL);
  assign pass_o          = (state == ST_PASS);
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_cnt;
  assign cycle_count_o   = cycle_cnt;
  assign commit_count_o  = commit_cnt;
  assign first_err_rd_o  = ferr_rd;
  assign first_err_got_o = ferr_got;
  assign first_err_exp_o = ferr_exp;

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed bench: dut_a is fail-fast with a long watchdog,
// dut_b counts errors and has a 16-cycle watchdog.
module tb_wb_commit_checker;
  import wb_check_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fv = 1'b0;
  logic [31:0] fi = '0;
  logic        cv = 1'b0;
  logic [4:0]  crd = '0;
  logic [31:0] cd = '0;
  logic        ev = 1'b0;
  logic [4:0]  erd = '0;
  logic [31:0] ed = '0;

  logic        a_rdy, a_done, a_pass, a_to;
  logic [15:0] a_err, a_cyc, a_cmt;
  logic [4:0]  a_frd;
  logic [31:0] a_fgot, a_fexp;
  logic        b_rdy, b_done, b_pass, b_to;
  logic [15:0] b_err, b_cyc, b_cmt;
  logic [4:0]  b_frd;
  logic [31:0] b_fgot, b_fexp;

  int n_chk = 0;
  int n_err = 0;
  entry_t tbl [8];

  always #5 clk = ~clk;

  wb_commit_checker #(
    .FAIL_FAST (1), .MAX_CYCLES (1024)
  ) dut_a (
    .clk_i (clk), .rst_n (rst_n), .start_i (start),
    .fetch_valid_i (fv), .fetch_instr_i (fi),
    .commit_valid_i (cv), .commit_rd_i (crd),
    .commit_data_i (cd), .exp_valid_i (ev),
    .exp_ready_o (a_rdy), .exp_rd_i (erd),
    .exp_data_i (ed), .done_o (a_done),
    .pass_o (a_pass), .timeout_o (a_to),
    .err_count_o (a_err), .cycle_count_o (a_cyc),
    .commit_count_o (a_cmt), .first_err_rd_o (a_frd),
    .first_err_got_o (a_fgot),
    .first_err_exp_o (a_fexp)
  );

  wb_commit_checker #(
    .FAIL_FAST (0), .MAX_CYCLES (16)
  ) dut_b (
    .clk_i (clk), .rst_n (rst_n), .start_i (start),
    .fetch_valid_i (fv), .fetch_instr_i (fi),
    .commit_valid_i (cv), .commit_rd_i (crd),
    .commit_data_i (cd), .exp_valid_i (ev),
    .exp_ready_o (b_rdy), .exp_rd_i (erd),
    .exp_data_i (ed), .done_o (b_done),
    .pass_o (b_pass), .timeout_o (b_to),
    .err_count_o (b_err), .cycle_count_o (b_cyc),
    .commit_count_o (b_cmt), .first_err_rd_o (b_frd),
    .first_err_got_o (b_fgot),
    .first_err_exp_o (b_fexp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_a_done", a_done, 0);
    chk("rst_a_pass", a_pass, 0);
    chk("rst_a_to", a_to, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_cyc", a_cyc, 0);
    chk("rst_a_rdy", a_rdy, 1);
    chk("rst_b_frd", b_frd, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // clean run to PASS
    do_start();
    chk("t1_a_to_clr", a_to, 0);
    ev = 1; erd = 1; ed = 5; tick();
    erd = 2; ed = 7; tick();
    ev = 0;
    cv = 1; crd = 1; cd = 5; tick();
    crd = 2; cd = 7; tick();
    cv = 0;
    fv = 1; fi = 0; tick();
    tick();
    fv = 0;
    repeat (3) tick();
    chk("t1_done_early", a_done, 0);
    tick();
    chk("t1_done", a_done, 1);
    chk("t1_pass", a_pass, 1);
    chk("t1_err", a_err, 0);
    chk("t1_cmt", a_cmt, 2);
    chk("t1_cyc", a_cyc, 10);
    chk("t1_to", a_to, 0);

    // fail-fast mismatch
    do_start();
    chk("t2_done_clr", a_done, 0);
    ev = 1; erd = 3; ed = 9; tick();
    ev = 0;
    cv = 1; crd = 3; cd = 8; tick();
    cv = 0;
    chk("t2_done", a_done, 1);
    chk("t2_pass", a_pass, 0);
    chk("t2_frd", a_frd, 3);
    chk("t2_fgot", a_fgot, 8);
    chk("t2_fexp", a_fexp, 9);
    chk("t2_err", a_err, 1);
    chk("t2_to", a_to, 0);

    // error counting without fail-fast
    do_start();
    ev = 1; erd = 4; ed = 1; tick();
    erd = 5; ed = 2; tick();
    ev = 0;
    cv = 1; crd = 4; cd = 32'h11; tick();
    chk("t3_err1", b_err, 1);
    chk("t3_run1", b_done, 0);
    crd = 6; cd = 2; tick();
    cv = 0;
    chk("t3_err2", b_err, 2);
    chk("t3_run2", b_done, 0);
    fv = 1; fi = 0; tick();
    fv = 0;
    repeat (4) tick();
    chk("t3_done_early", b_done, 0);
    tick();
    chk("t3_done", b_done, 1);
    chk("t3_pass", b_pass, 0);
    chk("t3_err", b_err, 2);
    chk("t3_frd", b_frd, 4);
    chk("t3_fgot", b_fgot, 32'h11);
    chk("t3_fexp", b_fexp, 1);
    chk("t3_cmt", b_cmt, 0);
    chk("t3_cyc", b_cyc, 10);

    // commit against empty FIFO, same-cycle push
    do_start();
    ev = 1; erd = 7; ed = 3;
    cv = 1; crd = 7; cd = 3; tick();
    ev = 0;
    chk("t4_err", b_err, 1);
    chk("t4_frd", b_frd, 7);
    chk("t4_fgot", b_fgot, 3);
    chk("t4_fexp0", b_fexp, 0);
    chk("t4_cmt0", b_cmt, 0);
    tick();
    cv = 0;
    chk("t4_cmt1", b_cmt, 1);
    chk("t4_err_keep", b_err, 1);

    // watchdog
    do_start();
    chk("t5_to_clr", b_to, 0);
    repeat (15) tick();
    chk("t5_done_early", b_done, 0);
    tick();
    chk("t5_done", b_done, 1);
    chk("t5_to", b_to, 1);
    chk("t5_pass", b_pass, 0);
    chk("t5_cyc", b_cyc, 16);

    // full FIFO, blocked push, r0 commit
    for (int i = 0; i < 8; i++) begin
      tbl[i].rd = 5'(i + 1);
      tbl[i].data = 32'((i + 1) * 10);
    end
    do_start();
    for (int i = 0; i < 8; i++) begin
      ev = 1; erd = tbl[i].rd; ed = tbl[i].data;
      tick();
    end
    chk("t6_full", a_rdy, 0);
    erd = 9; ed = 90;
    cv = 1; crd = tbl[0].rd; cd = tbl[0].data;
    tick();
    ev = 0;
    chk("t6_rdy", a_rdy, 1);
    chk("t6_cmt1", a_cmt, 1);
    crd = 0; cd = 123; tick();
    chk("t6_r0_err", a_err, 0);
    chk("t6_r0_cmt", a_cmt, 1);
    for (int i = 1; i < 8; i++) begin
      crd = tbl[i].rd; cd = tbl[i].data;
      tick();
    end
    cv = 0;
    chk("t6_cmt8", a_cmt, 8);
    chk("t6_err", a_err, 0);
    fv = 1; fi = 0; tick();
    fv = 0;
    repeat (5) tick();
    chk("t6_done", a_done, 1);
    chk("t6_pass", a_pass, 1);

    // async reset in DRAIN
    do_start();
    fv = 1; fi = 0; tick();
    fv = 0;
    tick();
    chk("t7_cyc_pre", a_cyc, 2);
    rst_n = 1'b0;
    #1;
    chk("t7_cyc", a_cyc, 0);
    chk("t7_done", a_done, 0);
    chk("t7_pass", a_pass, 0);
    chk("t7_to", a_to, 0);
    chk("t7_rdy", a_rdy, 1);
    chk("t7_b_cyc", b_cyc, 0);
    chk("t7_b_frd", b_frd, 0);
    tick();
    chk("t7_idle_cyc", a_cyc, 0);
    rst_n = 1'b1;
    tick();
    chk("t7_idle_hold", a_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
